// File: rtl/scrambled_pkt_reader.sv
// Ping-pong capture of scrambled TS payload, header re-attach with patched scrambling bits, 188-byte stream out.
// Optional PKT_STAT_EN adds pkt_cnt/drop_cnt statistics outputs.
module scrambled_pkt_reader #(
    parameter int PKT_LEN = 188,
    parameter int HDR_LEN = 4,
    parameter int AW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sb,
    input  logic [7:0]  scwadd,
    input  logic        scwe,
    input  logic        scend,
    input  logic [31:0] pkt_hdr,
    input  logic        o_e,
    input  logic        enc,
    output logic        wr_rdy,
    output logic [7:0]  ts_data,
    output logic        ts_valid,
    output logic        ts_sop,
    output logic        ts_eop,
    input  logic        ts_ready,
    output logic        ovf_err
`ifdef PKT_STAT_EN
    ,
    output logic [15:0] pkt_cnt,
    output logic [15:0] drop_cnt
`endif
);
    // state | meaning
    // IDLE  | no full bank on the read side
    // HDR   | emitting latched header bytes, cnt 0..HDR_LEN-1
    // PAY   | emitting buffered payload, cnt HDR_LEN..PKT_LEN-1
    localparam int PAY_LEN = PKT_LEN - HDR_LEN;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [1:0]  full, full_n;
    logic        wbank, rbank;
    logic [31:0] hdr_q [2];
    logic [7:0]  mem [2][2**AW];

    logic        wr_ok, fill, drop, ld, emit, free_bank;
    logic        rd_avail, nxt_avail;
    logic [7:0]  byte_n;
    logic [AW-1:0] rd_addr;

    assign wr_ok   = scwe && !full[wbank] && (int'(scwadd) < PAY_LEN);
    assign fill    = scend && !full[wbank];
    assign drop    = scend && full[wbank];
    assign wr_rdy  = !full[wbank];
    assign ld      = !ts_valid || ts_ready;
    assign rd_addr = AW'(cnt - 8'(HDR_LEN));

    // A bank completed this cycle counts as available so the reader starts without an extra idle cycle.
    assign rd_avail  = full[rbank]  || (fill && (wbank == rbank));
    assign nxt_avail = full[~rbank] || (fill && (wbank != rbank));

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wbank][AW'(scwadd)] <= sb;
    end

    always_comb begin
        full_n = full;
        if (free_bank)
            full_n[rbank] = 1'b0;
        if (fill)
            full_n[wbank] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full     <= 2'b00;
            wbank    <= 1'b0;
            rbank    <= 1'b0;
            ovf_err  <= 1'b0;
            hdr_q[0] <= 32'h0;
            hdr_q[1] <= 32'h0;
        end else begin
            full <= full_n;
            if (fill) begin
                hdr_q[wbank] <= {pkt_hdr[31:8], (enc ? {1'b1, o_e} : 2'b00), pkt_hdr[5:0]};
                wbank        <= ~wbank;
            end
            if (drop)
                ovf_err <= 1'b1;
            if (free_bank)
                rbank <= ~rbank;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        emit      = 1'b0;
        free_bank = 1'b0;
        byte_n    = 8'h00;
        case (state)
            S_IDLE: begin
                if (rd_avail) begin
                    state_n = S_HDR;
                    cnt_n   = 8'd0;
                end
            end
            S_HDR: begin
                case (cnt[1:0])
                    2'd0:    byte_n = hdr_q[rbank][31:24];
                    2'd1:    byte_n = hdr_q[rbank][23:16];
                    2'd2:    byte_n = hdr_q[rbank][15:8];
                    default: byte_n = hdr_q[rbank][7:0];
                endcase
                if (ld) begin
                    emit  = 1'b1;
                    cnt_n = cnt + 8'd1;
                    if (cnt == 8'(HDR_LEN - 1))
                        state_n = S_PAY;
                end
            end
            S_PAY: begin
                byte_n = mem[rbank][rd_addr];
                if (ld) begin
                    emit = 1'b1;
                    if (cnt == 8'(PKT_LEN - 1)) begin
                        // Last byte is in the output register; the bank can go back to the writer.
                        free_bank = 1'b1;
                        cnt_n     = 8'd0;
                        state_n   = nxt_avail ? S_HDR : S_IDLE;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_valid <= 1'b0;
            ts_data  <= 8'h00;
            ts_sop   <= 1'b0;
            ts_eop   <= 1'b0;
        end else if (ld) begin
            ts_valid <= emit;
            ts_sop   <= emit && (cnt == 8'd0);
            ts_eop   <= emit && (cnt == 8'(PKT_LEN - 1));
            if (emit)
                ts_data <= byte_n;
        end
    end

`ifdef PKT_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt  <= 16'd0;
            drop_cnt <= 16'd0;
        end else begin
            if (ts_valid && ts_ready && ts_eop)
                pkt_cnt <= pkt_cnt + 16'd1;
            if (drop)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_scrambled_pkt_reader.sv
// Bench for scrambled_pkt_reader: random payloads/headers checked against a packet-level queue model.
// Checks pkt_cnt/drop_cnt too when PKT_STAT_EN is defined.
module tb_scrambled_pkt_reader;
    localparam int PKT = 188;
    localparam int PAY = 184;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  sb = 8'h00;
    logic [7:0]  scwadd = 8'h00;
    logic        scwe = 1'b0;
    logic        scend = 1'b0;
    logic [31:0] pkt_hdr = 32'h0;
    logic        o_e = 1'b0;
    logic        enc = 1'b0;
    logic        wr_rdy;
    logic [7:0]  ts_data;
    logic        ts_valid;
    logic        ts_sop;
    logic        ts_eop;
    logic        ts_ready = 1'b0;
    logic        ovf_err;
`ifdef PKT_STAT_EN
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;
`endif

    int total = 0;
    int bad = 0;
    int ready_mode = 0;
    logic [7:0] pay [PAY];
    logic [9:0] rx_q [$];
    logic [9:0] exp_q [$];
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit         in_pkt = 1'b0;

    scrambled_pkt_reader dut (
        .clk(clk), .rst(rst), .sb(sb), .scwadd(scwadd), .scwe(scwe), .scend(scend),
        .pkt_hdr(pkt_hdr), .o_e(o_e), .enc(enc), .wr_rdy(wr_rdy), .ts_data(ts_data),
        .ts_valid(ts_valid), .ts_sop(ts_sop), .ts_eop(ts_eop), .ts_ready(ts_ready),
        .ovf_err(ovf_err)
`ifdef PKT_STAT_EN
        , .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ready_mode: 0 hold low, 1 hold high, 2 random 50%
    always @(posedge clk) begin
        #1;
        if (ready_mode == 2) ts_ready = 1'($urandom_range(0, 1));
        else                 ts_ready = (ready_mode == 1);
    end

    // Collects accepted bytes; flags data changing under stall and valid gaps inside a packet.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            in_pkt     = 1'b0;
        end else begin
            if (prev_stall) begin
                total++;
                if (ts_valid !== 1'b1 || ts_data !== prev_data) begin
                    bad++;
                    $display("FAIL stall_hold valid=%b data=%h required valid=1 data=%h", ts_valid, ts_data, prev_data);
                end
            end
            if (in_pkt) begin
                total++;
                if (ts_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL no_gap valid=%b required 1", ts_valid);
                end
            end
            if (ts_valid === 1'b1 && ts_ready === 1'b1) begin
                rx_q.push_back({ts_sop, ts_eop, ts_data});
                if (ts_sop) in_pkt = 1'b1;
                if (ts_eop) in_pkt = 1'b0;
            end
            prev_stall = (ts_valid === 1'b1) && (ts_ready === 1'b0);
            prev_data  = ts_data;
        end
    end

    // Reference: a packet is 4 header bytes (byte3[7:6] replaced) followed by the 184 payload bytes.
    task automatic push_exp(input logic [31:0] hdr, input logic oe, input logic en);
        logic [7:0] b3;
        b3 = hdr[7:0] & 8'h3F;
        if (en) b3 = b3 | 8'h80 | (oe ? 8'h40 : 8'h00);
        exp_q.push_back({2'b10, hdr[31:24]});
        exp_q.push_back({2'b00, hdr[23:16]});
        exp_q.push_back({2'b00, hdr[15:8]});
        exp_q.push_back({2'b00, b3});
        for (int i = 0; i < PAY; i++)
            exp_q.push_back({1'b0, 1'(i == PAY - 1), pay[i]});
    endtask

    task automatic rand_pay();
        for (int i = 0; i < PAY; i++) pay[i] = 8'($urandom);
    endtask

    // Writes pay[] in order; scend rides on the last write. Returns 1ns after the scend edge.
    task automatic write_pkt(input logic [31:0] hdr, input logic oe, input logic en);
        for (int i = 0; i < PAY; i++) begin
            @(posedge clk); #1;
            scwe = 1'b1; scwadd = 8'(i); sb = pay[i];
            scend = (i == PAY - 1);
            pkt_hdr = hdr; o_e = oe; enc = en;
        end
        @(posedge clk); #1;
        scwe = 1'b0; scend = 1'b0;
        pkt_hdr = $urandom; o_e = 1'($urandom); enc = 1'($urandom);
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        scwe = 1'b0; scend = 1'b0; ready_mode = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rx_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        @(posedge clk); #1;
        total++; if (wr_rdy !== 1'b1)    begin bad++; $display("FAIL rst_wr_rdy got=%b exp=1", wr_rdy); end
        total++; if (ts_valid !== 1'b0)  begin bad++; $display("FAIL rst_ts_valid got=%b exp=0", ts_valid); end
        total++; if (ts_sop !== 1'b0)    begin bad++; $display("FAIL rst_ts_sop got=%b exp=0", ts_sop); end
        total++; if (ts_eop !== 1'b0)    begin bad++; $display("FAIL rst_ts_eop got=%b exp=0", ts_eop); end
        total++; if (ts_data !== 8'h00)  begin bad++; $display("FAIL rst_ts_data got=%h exp=00", ts_data); end
        total++; if (ovf_err !== 1'b0)   begin bad++; $display("FAIL rst_ovf_err got=%b exp=0", ovf_err); end
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        bit ok;
        apply_reset();
        for (int i = 0; i < PAY; i++) pay[i] = 8'(i);
        push_exp(32'h47010010, 1'b1, 1'b1);
        write_pkt(32'h47010010, 1'b1, 1'b1);
        total++; if (ts_valid !== 1'b0) begin bad++; $display("FAIL latency_early valid=%b exp=0", ts_valid); end
        @(posedge clk); #1;
        total++;
        if (ts_valid !== 1'b1 || ts_data !== 8'h47 || ts_sop !== 1'b1) begin
            bad++; $display("FAIL latency_first v=%b d=%h sop=%b exp v=1 d=47 sop=1", ts_valid, ts_data, ts_sop);
        end
        ready_mode = 1;
        wait_rx(PKT, 1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout got=%0d exp=%0d", rx_q.size(), PKT); end
        total++; if (rx_q.size() > 3 && rx_q[3][7:0] !== 8'hD0) begin bad++; $display("FAIL single_byte3 got=%h exp=D0", rx_q[3][7:0]); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL single_byte[%0d] got=%h exp=%h", i, (i < rx_q.size()) ? rx_q[i] : 10'h3FF, exp_q[i]);
                break;
            end
        end
    endtask

    task automatic test_hdr_bits();
        bit ok;
        logic [31:0] h;
        apply_reset();
        ready_mode = 1;
        h = {8'h47, 16'($urandom), 8'hD5};
        rand_pay(); push_exp(h, 1'b1, 1'b0); write_pkt(h, 1'b1, 1'b0);
        h = {8'h47, 16'($urandom), 8'hD5};
        rand_pay(); push_exp(h, 1'b0, 1'b1); write_pkt(h, 1'b0, 1'b1);
        wait_rx(2 * PKT, 2000, ok);
        total++; if (!ok) begin bad++; $display("FAIL hdr_timeout got=%0d exp=%0d", rx_q.size(), 2 * PKT); end
        total++; if (rx_q.size() > 3 && rx_q[3][7:0] !== 8'h15) begin bad++; $display("FAIL hdr_clear got=%h exp=15", rx_q[3][7:0]); end
        total++; if (rx_q.size() > PKT + 3 && rx_q[PKT + 3][7:0] !== 8'h95) begin bad++; $display("FAIL hdr_even got=%h exp=95", rx_q[PKT + 3][7:0]); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL hdr_byte[%0d] got=%h exp=%h", i, (i < rx_q.size()) ? rx_q[i] : 10'h3FF, exp_q[i]);
                break;
            end
        end
    endtask

    task automatic test_random_ready();
        bit ok;
        logic [31:0] h;
        logic oe, en;
        apply_reset();
        ready_mode = 2;
        for (int p = 0; p < 20; p++) begin
            for (int c = 0; c < 2000 && wr_rdy !== 1'b1; c++) begin
                @(posedge clk); #1;
            end
            total++;
            if (wr_rdy !== 1'b1) begin
                bad++; $display("FAIL rand_wr_rdy_timeout pkt=%0d got=%b exp=1", p, wr_rdy);
                break;
            end
            h = $urandom; oe = 1'($urandom); en = 1'($urandom);
            rand_pay(); push_exp(h, oe, en); write_pkt(h, oe, en);
        end
        wait_rx(exp_q.size(), 20000, ok);
        total++; if (!ok) begin bad++; $display("FAIL rand_timeout got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL rand_byte[%0d] got=%h exp=%h", i, (i < rx_q.size()) ? rx_q[i] : 10'h3FF, exp_q[i]);
                break;
            end
        end
        total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL rand_ovf got=%b exp=0", ovf_err); end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [31:0] h;
        apply_reset();
        h = $urandom; rand_pay(); push_exp(h, 1'b1, 1'b1); write_pkt(h, 1'b1, 1'b1);
        total++; if (wr_rdy !== 1'b1) begin bad++; $display("FAIL ovf_wr_rdy1 got=%b exp=1", wr_rdy); end
        @(posedge clk); #1;
        scwe = 1'b1; scwadd = 8'd200; sb = 8'($urandom);
        @(posedge clk); #1;
        scwe = 1'b0;
        h = $urandom; rand_pay(); push_exp(h, 1'b0, 1'b0); write_pkt(h, 1'b0, 1'b0);
        total++; if (wr_rdy !== 1'b0) begin bad++; $display("FAIL ovf_wr_rdy2 got=%b exp=0", wr_rdy); end
        total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", ovf_err); end
        // third packet lands on full banks: its bytes and header must not appear anywhere
        h = $urandom; rand_pay(); write_pkt(h, 1'b1, 1'b1);
        total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf_err); end
`ifdef PKT_STAT_EN
        total++; if (drop_cnt !== 16'd1) begin bad++; $display("FAIL drop_cnt got=%0d exp=1", drop_cnt); end
`endif
        ready_mode = 1;
        wait_rx(2 * PKT, 2000, ok);
        total++; if (!ok) begin bad++; $display("FAIL ovf_timeout got=%0d exp=%0d", rx_q.size(), 2 * PKT); end
        repeat (300) @(posedge clk);
        #1;
        total++; if (rx_q.size() != 2 * PKT) begin bad++; $display("FAIL ovf_count got=%0d exp=%0d", rx_q.size(), 2 * PKT); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL ovf_byte[%0d] got=%h exp=%h", i, (i < rx_q.size()) ? rx_q[i] : 10'h3FF, exp_q[i]);
                break;
            end
        end
        total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf_err); end
`ifdef PKT_STAT_EN
        total++; if (pkt_cnt !== 16'd2) begin bad++; $display("FAIL pkt_cnt got=%0d exp=2", pkt_cnt); end
`endif
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [31:0] h;
        apply_reset();
        ready_mode = 1;
        h = $urandom; rand_pay(); write_pkt(h, 1'b1, 1'b0);
        wait_rx(104, 1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_timeout got=%0d exp=104", rx_q.size()); end
        rst = 1'b1;
        #1;
        total++; if (ts_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", ts_valid); end
        total++; if (wr_rdy !== 1'b1) begin bad++; $display("FAIL mid_wr_rdy got=%b exp=1", wr_rdy); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rx_q.delete(); exp_q.delete();
        h = $urandom; rand_pay(); push_exp(h, 1'b1, 1'b1); write_pkt(h, 1'b1, 1'b1);
        wait_rx(PKT, 1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_next_timeout got=%0d exp=%0d", rx_q.size(), PKT); end
        repeat (20) @(posedge clk);
        #1;
        total++; if (rx_q.size() != PKT) begin bad++; $display("FAIL mid_count got=%0d exp=%0d", rx_q.size(), PKT); end
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL mid_byte[%0d] got=%h exp=%h", i, (i < rx_q.size()) ? rx_q[i] : 10'h3FF, exp_q[i]);
                break;
            end
        end
        total++; if (wr_rdy !== 1'b1) begin bad++; $display("FAIL mid_wr_rdy_end got=%b exp=1", wr_rdy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_hdr_bits();
        test_random_ready();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
